// File: rtl/i2c_req_arbiter_if.sv
// Bundle between the requesters, the request arbiter and the shared I2C master.
// Requests are level valids held until a one-cycle req_ready pulse accepts them; rsp_valid is a one-cycle completion pulse with no backpressure.
interface i2c_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_rw;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*8-1:0]  req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [7:0]         rsp_rdata;
  logic               rsp_err;
  logic               m_start;
  logic               m_rw;
  logic [9:0]         m_addr;
  logic [7:0]         m_wdata;
  logic               m_busy;
  logic [7:0]         m_rdata;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, m_busy, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr, m_wdata
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, m_busy, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr, m_wdata
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter letting NREQ requesters share one I2C master, one transaction at a time,
// with a saturating per-wait-state timeout that completes the transaction with an error flag.
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  i2c_req_arbiter_if.slave  bus,
  output logic [2:0]        dbg_state
);
  localparam int GW = $clog2(NREQ);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant, grant, cand, gnt_q;
  logic            found;
  logic            accept;
  logic            timed_out;
  logic [15:0]     cnt;
  logic [7:0]      rdata_q;
  logic            err_q;
  logic            m_rw_q;
  logic [9:0]      m_addr_q;
  logic [7:0]      m_wdata_q;

  // Search starts one past the last completed grant and wraps, so every waiter sees at most NREQ-1 grants ahead of it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == GW'(NREQ - 1)) ? '0 : cand + GW'(1);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && found && !bus.m_busy;
  assign timed_out = (cnt >= TO_LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.m_busy)     state_nxt = RUN;
        else if (timed_out) state_nxt = DONE;
      end
      RUN:       if (!bus.m_busy || timed_out) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ - 1);
      gnt_q      <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_q     <= grant;
            m_rw_q    <= bus.req_rw[grant];
            m_addr_q  <= bus.req_addr[int'(grant)*10 +: 10];
            m_wdata_q <= bus.req_wdata[int'(grant)*8 +: 8];
          end
        end
        LAUNCH: begin
          cnt     <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        WAIT_BUSY: begin
          if (bus.m_busy)       cnt <= '0;
          else if (timed_out)   err_q <= 1'b1;
          else if (cnt != '1)   cnt <= cnt + 16'd1;
        end
        RUN: begin
          // rdata_q stays zero on the error path, so aborted reads return 8'h00.
          if (!bus.m_busy)      rdata_q <= m_rw_q ? bus.m_rdata : 8'h00;
          else if (timed_out)   err_q <= 1'b1;
          else if (cnt != '1)   cnt <= cnt + 16'd1;
        end
        DONE:    last_grant <= gnt_q;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (accept && !rst) ? (NREQ'(1) << grant) : '0;
  assign bus.rsp_valid = (state == DONE) ? (NREQ'(1) << gnt_q) : '0;
  assign bus.rsp_rdata = (state == DONE) ? rdata_q : 8'h00;
  assign bus.rsp_err   = (state == DONE) && err_q;
  assign bus.m_start   = (state == LAUNCH);
  assign bus.m_rw      = m_rw_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a master model, grant/command/response scoreboards and a
// second short-timeout instance for the abort path.
module tb_i2c_req_arbiter;
  localparam int NREQ = 4;
  localparam int W    = NREQ + 1 + 8;   // {rsp_valid, rsp_err, rsp_rdata}
  localparam int CW   = 1 + 10 + 8;     // {m_rw, m_addr, m_wdata}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();
  i2c_req_arbiter_if #(.NREQ(NREQ)) tbus ();
  logic [2:0] dbg_state, t_dbg_state;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(4095)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state));
  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut_to (
    .clk(clk), .rst(rst), .bus(tbus.slave), .dbg_state(t_dbg_state));

  int checks = 0, failures = 0;
  int acc_cnt = 0, rsp_cnt = 0;
  logic [NREQ-1:0] gnt_q[$];
  logic [CW-1:0]   cmd_q[$];
  logic [W-1:0]    exp_q[$];

  // Master model: busy one cycle after m_start, for busy_len cycles.
  int         busy_len = 20;
  logic [7:0] m_rdata_val = 8'h00;
  logic       model_busy = 1'b0;
  logic       ext_busy = 1'b0;
  assign bus.m_busy  = model_busy | ext_busy;
  assign bus.m_rdata = m_rdata_val;

  always @(negedge clk) begin
    if (bus.m_start && !rst) begin
      @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int t = 0; t < 300 && acc_cnt < target; t++) step();
    check(tag, acc_cnt, target);
  endtask

  task automatic wait_rsp(input int target, input string tag);
    for (int t = 0; t < 300 && rsp_cnt < target; t++) step();
    check(tag, rsp_cnt, target);
  endtask

  task automatic set_req(input int i, input logic rw, input logic [9:0] a, input logic [7:0] wd);
    bus.req_rw[i]           = rw;
    bus.req_addr[i*10 +: 10] = a;
    bus.req_wdata[i*8 +: 8]  = wd;
  endtask

  task automatic expect_txn(input int i, input logic rw, input logic [9:0] a, input logic [7:0] wd);
    gnt_q.push_back(NREQ'(1) << i);
    cmd_q.push_back({rw, a, wd});
    exp_q.push_back({NREQ'(1) << i, 1'b0, rw ? m_rdata_val : 8'h00});
  endtask

  task automatic single(input int i, input logic rw, input logic [9:0] a, input logic [7:0] wd, input string tag);
    int a0, r0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    set_req(i, rw, a, wd);
    expect_txn(i, rw, a, wd);
    bus.req_valid[i] = 1'b1;
    wait_acc(a0 + 1, {tag, "_accept"});
    bus.req_valid[i] = 1'b0;
    // Scramble the accepted requester's fields; the transaction in flight must not notice.
    set_req(i, ~rw, ~a, ~wd);
    wait_rsp(r0 + 1, {tag, "_rsp"});
    step();
  endtask

  task automatic grant_1010();
    int a0, r0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    m_rdata_val = 8'h6E;
    set_req(1, 1'b1, 10'h2A1, 8'h11);
    set_req(3, 1'b0, 10'h0C3, 8'h99);
    expect_txn(1, 1'b1, 10'h2A1, 8'h11);
    expect_txn(3, 1'b0, 10'h0C3, 8'h99);
    bus.req_valid = 4'b1010;
    wait_acc(a0 + 1, "acc_1010_first");
    bus.req_valid[1] = 1'b0;
    wait_acc(a0 + 2, "acc_1010_second");
    bus.req_valid[3] = 1'b0;
    wait_rsp(r0 + 2, "rsp_1010");
    step();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  logic          ready_prev = 1'b0, busy_prev = 1'b0, fall_prev = 1'b0;
  logic [CW-1:0] last_cmd = '0;

  always @(negedge clk) begin
    if (rst) begin
      ready_prev = 1'b0;
      busy_prev  = 1'b0;
      fall_prev  = 1'b0;
    end else begin
      check("ready_onehot0", 64'($onehot0(bus.req_ready)), 1);
      check("rsp_onehot0", 64'($onehot0(bus.rsp_valid)), 1);
      check("start_one_after_accept", bus.m_start, ready_prev);
      if (bus.req_ready != '0) begin
        acc_cnt++;
        if (gnt_q.size() == 0) check("unexpected_grant", bus.req_ready, 0);
        else                   check("grant", bus.req_ready, gnt_q.pop_front());
      end
      if (bus.m_start) begin
        if (cmd_q.size() == 0) check("unexpected_start", bus.m_start, 0);
        else begin
          last_cmd = cmd_q.pop_front();
          check("m_cmd", {bus.m_rw, bus.m_addr, bus.m_wdata}, last_cmd);
        end
      end
      if (bus.rsp_valid != '0) begin
        rsp_cnt++;
        check("m_cmd_held", {bus.m_rw, bus.m_addr, bus.m_wdata}, last_cmd);
        check("busy_fall_to_rsp", fall_prev, 1);
        if (exp_q.size() == 0) check("unexpected_rsp", bus.rsp_valid, 0);
        else check("rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, exp_q.pop_front());
      end
      ready_prev = (bus.req_ready != '0);
      fall_prev  = busy_prev && !bus.m_busy;
      busy_prev  = bus.m_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, n;
    logic got;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    tbus.req_valid = '0; tbus.req_rw = '0; tbus.req_addr = '0; tbus.req_wdata = '0;
    tbus.m_busy = 1'b0; tbus.m_rdata = 8'hFF;

    // Reset: outputs quiet even with requests pending.
    rst = 1'b1;
    bus.req_valid = 4'b1010;
    repeat (3) step();
    check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                            bus.m_start, bus.m_rw, bus.m_addr, bus.m_wdata}, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    grant_1010();

    // Single write, then read from requester 2.
    busy_len = 20;
    single(0, 1'b0, 10'h050, 8'hA5, "write0");
    m_rdata_val = 8'h5C;
    busy_len = 7;
    single(2, 1'b1, 10'h3FF, 8'h00, "read2");
    busy_len = 5;
    single(3, 1'b0, 10'h133, 8'h3D, "write3");

    // Fairness with all requesters held.
    busy_len = $urandom_range(2, 9);
    m_rdata_val = 8'h33;
    for (int i = 0; i < NREQ; i++) set_req(i, i[0], 10'(10'h100 + i), 8'(8'hC0 + i));
    for (int k = 0; k < 6; k++) expect_txn(k % NREQ, k[0], 10'(10'h100 + (k % NREQ)), 8'(8'hC0 + (k % NREQ)));
    a0 = acc_cnt;
    r0 = rsp_cnt;
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 1000 && acc_cnt < a0 + 6; t++) step();
    bus.req_valid = '0;
    check("fair_accepts", acc_cnt, a0 + 6);
    wait_rsp(r0 + 6, "fair_rsps");
    step();

    // Busy master holds off any grant while the arbiter is idle.
    busy_len = 4;
    ext_busy = 1'b1;
    set_req(0, 1'b0, 10'h1C0, 8'h3C);
    expect_txn(0, 1'b0, 10'h1C0, 8'h3C);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    bus.req_valid = 4'b0001;
    repeat (5) step();
    check("no_grant_while_busy", acc_cnt, a0);
    ext_busy = 1'b0;
    step();
    check("grant_after_busy_drop", acc_cnt, a0 + 1);
    bus.req_valid = '0;
    wait_rsp(r0 + 1, "ext_busy_rsp");
    step();

    // Reset in the middle of RUN.
    busy_len = 20;
    set_req(0, 1'b1, 10'h111, 8'h22);
    gnt_q.push_back(4'b0001);
    cmd_q.push_back({1'b1, 10'h111, 8'h22});
    a0 = acc_cnt;
    r0 = rsp_cnt;
    bus.req_valid = 4'b0001;
    wait_acc(a0 + 1, "rstcase_accept");
    bus.req_valid = '0;
    for (int t = 0; t < 40 && dbg_state != 3'd3; t++) step();
    check("rstcase_in_run", dbg_state, 3);
    rst = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    check("rst_async_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                                bus.m_start, bus.m_rw, bus.m_addr, bus.m_wdata}, 0);
    check("rst_async_state", dbg_state, 0);
    repeat (2) step();
    check("rst_no_rsp", rsp_cnt, r0);
    rst = 1'b0;
    busy_len = 6;
    grant_1010();

    // Timeout instance: the master never goes busy.
    tbus.req_rw = 4'b0001;
    tbus.req_addr[9:0] = 10'h2B7;
    tbus.req_wdata[7:0] = 8'h4D;
    tbus.req_valid = 4'b0001;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = tbus.req_ready[0];
    end
    check("to_accept", got, 1);
    step();
    tbus.req_valid = '0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = (tbus.rsp_valid != '0);
    end
    check("to_rsp_seen", got, 1);
    check("to_within_18", (n <= 18), 1);
    check("to_not_early", (n >= 15), 1);
    check("to_rsp", {tbus.rsp_valid, tbus.rsp_err, tbus.rsp_rdata}, {4'b0001, 1'b1, 8'h00});
    @(negedge clk);
    check("to_back_idle", t_dbg_state, 0);
    check("to_rsp_drop", tbus.rsp_valid, 0);

    check("gnt_q_drained", gnt_q.size(), 0);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
